sram_bus_arbiter: RTL and testbench

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_arbiter_if.sv | 24 ++
 rtl/sram_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// Request/response bus shared by the fetch master, the load/store master and
// the SRAM-like slave. A master drives the request fields and receives the
// accept/response strobes; the slave side is the mirror image.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter onto a single SRAM-like slave port. The load/store side
// normally wins; the fetch side is forced through after STARVE_LIM consecutive
// losses. Only one transaction is ever outstanding on the slave port, and the
// slave request fields come from registers so the slave never sees a master
// input combinationally.
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               resetn,
  sram_bus_arbiter_if.slave  inst,
  sram_bus_arbiter_if.slave  data,
  sram_bus_arbiter_if.master m
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic       OWN_DATA = 1'b0;
  localparam logic       OWN_INST = 1'b1;

  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        pick_inst;
  logic        addr_hs;
  logic        data_hs;

  // Arbitration: fetch wins only when it is alone or has been starved long enough.
  always_comb begin
    pick_inst = inst.req & (~data.req | (starve_q == LIM));
  end

  // Next-state: grant and latch in IDLE, wait for accept in REQ, wait for response in WAIT.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    wr_d     = wr_q;
    size_d   = size_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (inst.req | data.req) begin
          state_d = S_REQ;
          if (pick_inst) begin
            owner_d  = OWN_INST;
            starve_d = 3'd0;
            wr_d     = inst.wr;
            size_d   = inst.size;
            wstrb_d  = inst.wstrb;
            addr_d   = inst.addr;
            wdata_d  = inst.wdata;
          end else begin
            owner_d  = OWN_DATA;
            if (inst.req && (starve_q < LIM)) starve_d = starve_q + 3'd1;
            wr_d     = data.wr;
            size_d   = data.size;
            wstrb_d  = data.wstrb;
            addr_d   = data.addr;
            wdata_d  = data.wdata;
          end
        end
      end
      S_REQ: begin
        // A response strobe arriving together with the accept is not ours yet.
        if (m.addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m.data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_DATA;
      starve_q <= 3'd0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      wstrb_q  <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Slave request port comes purely from state and latched fields.
  assign m.req   = (state_q == S_REQ);
  assign m.wr    = wr_q;
  assign m.size  = size_q;
  assign m.wstrb = wstrb_q;
  assign m.addr  = addr_q;
  assign m.wdata = wdata_q;

  // Handshakes are routed only to the current owner, only in the matching state.
  assign addr_hs = (state_q == S_REQ)  & m.addr_ok;
  assign data_hs = (state_q == S_WAIT) & m.data_ok;

  assign inst.addr_ok = addr_hs & (owner_q == OWN_INST);
  assign data.addr_ok = addr_hs & (owner_q == OWN_DATA);
  assign inst.data_ok = data_hs & (owner_q == OWN_INST);
  assign data.data_ok = data_hs & (owner_q == OWN_DATA);

  // Read data is a plain wire; data_ok qualifies it.
  assign inst.rdata = m.rdata;
  assign data.rdata = m.rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios followed by randomized
// traffic, checked by a transaction-level reference model and a scoreboard.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  sram_bus_arbiter_if inst_bus ();
  sram_bus_arbiter_if data_bus ();
  sram_bus_arbiter_if m_bus ();

  sram_bus_arbiter #(.STARVE_LIM(LIM)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus),
    .data   (data_bus),
    .m      (m_bus)
  );

  typedef struct packed {
    logic        own_inst;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   total = 0;
  int   bad   = 0;
  txn_t exp_q[$];
  logic resp_q[$];
  logic grant_log[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the arbiter as a sequence of whole transactions.
  // phase 0 = free for a grant, 1 = request on slave port, 2 = awaiting response.
  int   phase  = 0;
  int   starve = 0;
  logic cur_inst = 1'b0;
  always @(negedge clk) begin
    logic [4:0] exp_hs;
    logic       take_inst;
    txn_t       t;
    exp_hs = 5'd0;
    if (!resetn) begin
      phase  = 0;
      starve = 0;
      exp_q.delete();
      resp_q.delete();
    end else begin
      case (phase)
        0: if (inst_bus.req || data_bus.req) begin
          take_inst = inst_bus.req && (!data_bus.req || starve == LIM);
          t.own_inst = take_inst;
          if (take_inst) begin
            t.wr = inst_bus.wr; t.size = inst_bus.size; t.wstrb = inst_bus.wstrb;
            t.addr = inst_bus.addr; t.wdata = inst_bus.wdata;
            starve = 0;
          end else begin
            t.wr = data_bus.wr; t.size = data_bus.size; t.wstrb = data_bus.wstrb;
            t.addr = data_bus.addr; t.wdata = data_bus.wdata;
            if (inst_bus.req && starve < LIM) starve++;
          end
          exp_q.push_back(t);
          cur_inst = take_inst;
          phase = 1;
        end
        1: begin
          exp_hs[4] = 1'b1;
          if (m_bus.addr_ok) begin
            exp_hs[3] = cur_inst;
            exp_hs[2] = !cur_inst;
            phase = 2;
          end
        end
        default: if (m_bus.data_ok) begin
          exp_hs[1] = cur_inst;
          exp_hs[0] = !cur_inst;
          phase = 0;
        end
      endcase
    end
    check("handshakes",
          {m_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok},
          exp_hs);
    check("rdata_pass", {inst_bus.rdata, data_bus.rdata}, {m_bus.rdata, m_bus.rdata});
  end

  // Monitor: compares what the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    txn_t t;
    logic own;
    if (m_bus.req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_req", 1, 0);
      end else begin
        t = exp_q[0];
        check("m_fields", {m_bus.wr, m_bus.size, m_bus.wstrb, m_bus.addr, m_bus.wdata},
              {t.wr, t.size, t.wstrb, t.addr, t.wdata});
        if (m_bus.addr_ok) begin
          void'(exp_q.pop_front());
          check("addr_ok_owner", {inst_bus.addr_ok, data_bus.addr_ok}, {t.own_inst, !t.own_inst});
          resp_q.push_back(t.own_inst);
        end
      end
    end
    if (inst_bus.addr_ok || data_bus.addr_ok) grant_log.push_back(inst_bus.addr_ok);
    if (inst_bus.data_ok || data_bus.data_ok) begin
      if (resp_q.size() == 0) begin
        check("unexpected_data_ok", 1, 0);
      end else begin
        own = resp_q.pop_front();
        check("data_ok_owner", {inst_bus.data_ok, data_bus.data_ok}, {own, !own});
        check("rdata_ret", own ? inst_bus.rdata : data_bus.rdata, m_bus.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.wstrb = 0;
    inst_bus.addr = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.wstrb = 0;
    data_bus.addr = 0; data_bus.wdata = 0;
    m_bus.addr_ok = 0; m_bus.data_ok = 0; m_bus.rdata = 0;
  endtask

  task automatic set_data(input logic wr, input logic [3:0] wstrb, input logic [31:0] addr,
                          input logic [31:0] wdata);
    data_bus.req = 1; data_bus.wr = wr; data_bus.size = 2'd2; data_bus.wstrb = wstrb;
    data_bus.addr = addr; data_bus.wdata = wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic ia, da;
    idle_inputs();
    #1 resetn = 0;
    // Reset holds everything quiet even with a pending request and a ready slave.
    set_data(1'b1, 4'hf, 32'h1234_5678, 32'hcafe_f00d);
    m_bus.addr_ok = 1;
    tick(); tick();
    @(negedge clk);
    check("reset_m_req", m_bus.req, 0);
    check("reset_fields", {m_bus.wr, m_bus.size, m_bus.wstrb, m_bus.addr, m_bus.wdata}, 0);
    check("reset_addr_ok", {inst_bus.addr_ok, data_bus.addr_ok}, 0);
    idle_inputs();
    tick();
    resetn = 1;
    tick();

    // Single load with fixed timing.
    set_data(1'b0, 4'h0, 32'h1c00_0100, 32'h0);            // cycle 0
    @(negedge clk); check("load_c0_m_req", m_bus.req, 0);
    tick();                                                 // cycle 1
    @(negedge clk); check("load_c1_m_req", m_bus.req, 1);
    check("load_c1_addr", m_bus.addr, 32'h1c00_0100);
    tick(); m_bus.addr_ok = 1;                              // cycle 2
    @(negedge clk); check("load_c2_addr_ok", {inst_bus.addr_ok, data_bus.addr_ok}, 2'b01);
    tick(); m_bus.addr_ok = 0; data_bus.req = 0;            // cycle 3
    @(negedge clk); check("load_c3_m_req", m_bus.req, 0);
    tick(); m_bus.data_ok = 1; m_bus.rdata = 32'hdead_beef; // cycle 4
    @(negedge clk); check("load_c4_data_ok", {inst_bus.data_ok, data_bus.data_ok}, 2'b01);
    check("load_c4_rdata", data_bus.rdata, 32'hdead_beef);
    tick(); m_bus.data_ok = 0;
    tick();

    // Both masters hold requests, slave always ready: data x4, inst, data.
    grant_log.delete();
    inst_bus.req = 1; inst_bus.addr = 32'h0000_4000; inst_bus.size = 2'd2;
    set_data(1'b0, 4'h0, 32'h0000_8000, 32'h0);
    m_bus.addr_ok = 1; m_bus.data_ok = 1; m_bus.rdata = 32'h5555_aaaa;
    n = 0;
    @(negedge clk);
    while (grant_log.size() < 6 && n < 40) begin
      tick(); @(negedge clk); n++;
    end
    check("starve_grant_count", grant_log.size() >= 6, 1);
    if (grant_log.size() >= 6) begin
      check("starve_g1", grant_log[0], 0);
      check("starve_g2", grant_log[1], 0);
      check("starve_g3", grant_log[2], 0);
      check("starve_g4", grant_log[3], 0);
      check("starve_g5", grant_log[4], 1);
      check("starve_g6", grant_log[5], 0);
    end
    tick(); idle_inputs();
    tick(); tick(); tick();

    // Stalled slave while the master fields churn: latched request stays put.
    set_data(1'b1, 4'h3, 32'h0000_0a00, 32'h1111_2222);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      data_bus.addr = $urandom; data_bus.wdata = $urandom; data_bus.wstrb = 4'($urandom);
      data_bus.req = 1'($urandom); inst_bus.req = 1'($urandom);
      @(negedge clk);
      check("stall_fields", {m_bus.req, m_bus.addr, m_bus.wdata, m_bus.wstrb},
            {1'b1, 32'h0000_0a00, 32'h1111_2222, 4'h3});
      check("stall_no_addr_ok", {inst_bus.addr_ok, data_bus.addr_ok}, 0);
      tick();
    end
    m_bus.addr_ok = 1; data_bus.req = 0; inst_bus.req = 0;
    @(negedge clk); check("stall_accept", data_bus.addr_ok, 1);
    tick(); m_bus.addr_ok = 0; m_bus.data_ok = 1;
    @(negedge clk); check("stall_done", data_bus.data_ok, 1);
    tick(); idle_inputs();
    tick();

    // Store where accept and response coincide: the response waits for WAIT.
    set_data(1'b1, 4'b0100, 32'h0000_0c04, 32'h00ab_0000);
    tick(); m_bus.addr_ok = 1; m_bus.data_ok = 1;
    @(negedge clk); check("store_same_cycle", {data_bus.addr_ok, data_bus.data_ok}, 2'b10);
    check("store_wstrb", m_bus.wstrb, 4'b0100);
    tick(); data_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 0;
    @(negedge clk); check("store_wait_quiet", data_bus.data_ok, 0);
    tick(); m_bus.data_ok = 1;
    @(negedge clk); check("store_done", data_bus.data_ok, 1);
    tick(); m_bus.data_ok = 0;
    tick();

    // Reset during WAIT abandons the transaction.
    set_data(1'b0, 4'h0, 32'h0000_0d00, 32'h0);
    tick(); m_bus.addr_ok = 1;
    tick(); data_bus.req = 0; m_bus.addr_ok = 0; resetn = 0; m_bus.data_ok = 1;
    @(negedge clk); check("rst_wait_data_ok", {inst_bus.data_ok, data_bus.data_ok, m_bus.req}, 0);
    tick(); resetn = 1;
    set_data(1'b0, 4'h0, 32'h0000_0e00, 32'h0);
    @(negedge clk); check("rst_release_quiet", {data_bus.data_ok, m_bus.req}, 0);
    tick(); m_bus.data_ok = 0;
    @(negedge clk); check("rst_regrant", {m_bus.req, m_bus.addr}, {1'b1, 32'h0000_0e00});
    m_bus.addr_ok = 1;
    tick(); data_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 1;
    tick(); idle_inputs();
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = inst_bus.addr_ok;
      da = data_bus.addr_ok;
      tick();
      if (ia) inst_bus.req = 0;
      if (da) data_bus.req = 0;
      if (!inst_bus.req && $urandom_range(2) == 0) begin
        inst_bus.req = 1; inst_bus.wr = 1'($urandom); inst_bus.size = 2'($urandom);
        inst_bus.wstrb = 4'($urandom); inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
      end
      if (!data_bus.req && $urandom_range(2) == 0) begin
        data_bus.req = 1; data_bus.wr = 1'($urandom); data_bus.size = 2'($urandom);
        data_bus.wstrb = 4'($urandom); data_bus.addr = $urandom; data_bus.wdata = $urandom;
      end
      m_bus.addr_ok = 1'($urandom);
      m_bus.data_ok = 1'($urandom);
      m_bus.rdata   = $urandom;
      resetn = ($urandom_range(299) != 0);
    end
    tick(); resetn = 1; idle_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
